spi_master_arbiter: RTL and testbench
=====================================

# spi_master_arbiter

Round-robin arbiter and transaction sequencer that shares one SPI master byte engine between `NUM_REQ` requesters. It sits between client logic (counter sources, register pollers) and the SPI master core. It grants one requester at a time and owns chip-select `n_SS` for the whole multi-byte burst. Per burst it sequences setup and hold timing, per-byte start/done handshakes, TX byte fetch and RX byte return.

## Interface
- `NUM_REQ`, 2, number of requesters (2..8)
- `LEN_W`, 4, width of per-request byte count
- `SETUP_CYC`, 2, clk cycles from `n_SS` low to first `spi_start` (≥1)
- `HOLD_CYC`, 2, clk cycles from last `spi_done` to `n_SS` high (≥1)
- `GAP_CYC`, 1, minimum `n_SS`-high cycles between bursts (≥1)

- `clk` in 1: system clock; single clock domain
- `reset` in 1: synchronous, active-high reset
- `req_valid` in NUM_REQ: request level per requester; sampled only in IDLE
- `req_len` in NUM_REQ*LEN_W: byte count per requester, packed, requester i at [i*LEN_W +: LEN_W]
- `tx_data` in NUM_REQ*8: next TX byte per requester, packed
- `grant` out NUM_REQ: one-hot owner, held for the whole burst
- `tx_pop` out NUM_REQ: 1-cycle pulse; granted requester's `tx_data` consumed
- `rx_data` out 8: received byte, shared by all requesters
- `rx_valid` out NUM_REQ: 1-cycle pulse to owner; `rx_data` valid
- `req_done` out NUM_REQ: 1-cycle pulse at burst end
- `busy` out 1: high in every state except IDLE
- `spi_start` out 1: 1-cycle byte start to the SPI master
- `spi_tx_data` out 8: byte presented with `spi_start`
- `spi_ready` in 1: SPI master is able to accept `spi_start`
- `spi_rx_data` in 8: byte received by the SPI master; valid with `spi_done`
- `spi_done` in 1: 1-cycle pulse when a byte completes
- `n_SS` out 1: active-low slave select

## Operation
- Reset values: `grant`=0, `tx_pop`=0, `rx_valid`=0, `req_done`=0, `rx_data`=0, `spi_start`=0, `spi_tx_data`=0, `busy`=0, `n_SS`=1, state=IDLE, RR pointer=NUM_REQ-1 so requester 0 wins first, byte counter=0.
- FSM states: IDLE, SETUP, XFER, WAIT, HOLD, GAP.
- IDLE:
  - If any `req_valid` is high, the winner is the first set bit searched from pointer+1, wrapping modulo NUM_REQ.
  - On the winner, register `grant`, latch `req_len` into the byte counter (0 is treated as 1), set pointer = winner, drive `n_SS`=0, go to SETUP.
- SETUP: count SETUP_CYC cycles, then go to XFER.
- XFER:
  - Wait for `spi_ready`=1.
  - On that cycle, pulse `spi_start`, drive `spi_tx_data` = owner's `tx_data`, pulse `tx_pop[owner]`, go to WAIT.
- WAIT:
  - On `spi_done`, register `rx_data` = `spi_rx_data` and pulse `rx_valid[owner]` next cycle, then decrement the counter.
  - If the counter was 1, go to HOLD; otherwise go to XFER.
- HOLD: count HOLD_CYC cycles, then drive `n_SS`=1, clear `grant`, pulse `req_done[owner]`, go to GAP.
- GAP: count GAP_CYC cycles, then go to IDLE.
- Boundary rules:
  - Deasserting `req_valid` mid-burst has no effect; the burst completes.
  - `spi_done` outside WAIT is ignored.
  - `spi_ready` low stalls XFER indefinitely with `n_SS` held low.
  - A requester holding `req_valid` after `req_done` rearbitrates in IDLE and loses to any other pending requester.
  - The counter counts down only, with no wrap; max burst is 2^LEN_W−1 bytes.
  - Reset asserted in any state forces all reset values on the next edge: `n_SS` high, no pulses, burst abandoned.

## Timing
- Request seen in IDLE at cycle T → `grant` and `n_SS`=0 at T+1.
- First `spi_start` at T+1+SETUP_CYC when `spi_ready` is high.
- `tx_pop` and `spi_start` coincide; the requester presents its next byte by the following cycle.
- `spi_done` at cycle D → `rx_valid`/`rx_data` at D+1.
- Next `spi_start` no earlier than D+1.
- After the last `spi_done` at D: `n_SS`=1, `req_done`, and `grant`=0 at D+1+HOLD_CYC.
- The next grant is no earlier than D+2+HOLD_CYC+GAP_CYC.
- Consecutive bursts therefore have `n_SS` high for ≥ GAP_CYC+1 cycles.

## Test plan
- Single burst: req0 with len=2, tx 0xA5 then 0x3C, slave returns 0x11, 0x22.
  - Required: two `spi_start` pulses with 0xA5 then 0x3C.
  - `rx_valid[0]` pulses with 0x11 then 0x22.
  - `n_SS` low throughout; `req_done[0]` exactly once; SETUP and HOLD spacing = 2 cycles.
- Simultaneous requests: req0 and req1 both with len=1, held high continuously.
  - Required: grants alternate 0,1,0,1.
  - `n_SS` high ≥2 cycles between bursts; `grant` never has two bits set.
- len=0: req1 with len=0.
  - Required: exactly one byte is transferred, then `req_done[1]`.
- Stall: `spi_ready` low for 10 cycles in XFER.
  - Required: no `spi_start` and no `tx_pop` while stalled; `n_SS` stays low.
  - `spi_start` occurs in the cycle `spi_ready` rises.
- Spurious/abort: a `spi_done` pulse during SETUP, then `req_valid` dropped mid-burst of len=3.
  - Required: the spurious done is ignored; all 3 bytes complete.
- Reset mid-burst: `reset` asserted during WAIT of the 2nd byte.
  - Required: next cycle `n_SS`=1, `grant`=0, `busy`=0, no `req_done`.
  - After release with both requests held, requester 0 is granted first.

Source files
------------

// File: rtl/spi_master_arbiter_if.sv
// Requester and SPI-engine signal bundle for spi_master_arbiter.
// master = arbiter side, slave = requesters plus SPI byte engine.
interface spi_master_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int LEN_W = 4
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ*8-1:0]     tx_data;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       tx_pop;
  logic [7:0]               rx_data;
  logic [NUM_REQ-1:0]       rx_valid;
  logic [NUM_REQ-1:0]       req_done;
  logic                     busy;
  logic                     spi_start;
  logic [7:0]               spi_tx_data;
  logic                     spi_ready;
  logic [7:0]               spi_rx_data;
  logic                     spi_done;
  logic                     n_SS;

  modport master (
    input  req_valid, req_len, tx_data,
    input  spi_ready, spi_rx_data, spi_done,
    output grant, tx_pop, rx_data, rx_valid,
    output req_done, busy, spi_start,
    output spi_tx_data, n_SS
  );

  modport slave (
    output req_valid, req_len, tx_data,
    output spi_ready, spi_rx_data, spi_done,
    input  grant, tx_pop, rx_data, rx_valid,
    input  req_done, busy, spi_start,
    input  spi_tx_data, n_SS
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// Round-robin owner of one SPI byte engine across NUM_REQ requesters.
// Holds n_SS low for a whole burst with setup, hold and gap timing.
module spi_master_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int LEN_W = 4,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC = 2,
  parameter int GAP_CYC = 1
) (
  input logic clk,
  input logic reset,
  spi_master_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int T1 =
    SETUP_CYC > HOLD_CYC ? SETUP_CYC : HOLD_CYC;
  localparam int TMAX = T1 > GAP_CYC ? T1 : GAP_CYC;
  localparam int TW = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, XFER, WAIT, HOLD, GAP
  } state_t;

  state_t state, state_n;

  logic [IW-1:0]      ptr, ptr_n;
  logic [IW-1:0]      own, own_n;
  logic [IW-1:0]      win;
  logic [IW:0]        aidx;
  logic               found;
  logic [LEN_W-1:0]   cnt, cnt_n;
  logic [LEN_W-1:0]   win_len;
  logic [TW-1:0]      tmr, tmr_n;
  logic [NUM_REQ-1:0] grant, grant_n;
  logic [NUM_REQ-1:0] rx_valid, rx_valid_n;
  logic [NUM_REQ-1:0] req_done, req_done_n;
  logic [NUM_REQ-1:0] tx_pop, own_oh;
  logic [7:0]         rx_data, rx_data_n;
  logic [7:0]         spi_tx_data;
  logic               spi_start;
  logic               n_ss, n_ss_n;

  // first pending requester after the last owner, wrapping
  always_comb begin
    found = 1'b0;
    win = '0;
    aidx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      aidx = {1'b0, ptr} + (IW+1)'(i);
      if (aidx >= (IW+1)'(NUM_REQ))
        aidx = aidx - (IW+1)'(NUM_REQ);
      if (!found && bus.req_valid[aidx[IW-1:0]]) begin
        found = 1'b1;
        win = aidx[IW-1:0];
      end
    end
  end

  assign win_len =
    bus.req_len[int'(win)*LEN_W +: LEN_W];
  assign own_oh = NUM_REQ'(1) << own;

  always_comb begin
    state_n = state;
    ptr_n = ptr;
    own_n = own;
    cnt_n = cnt;
    tmr_n = tmr;
    grant_n = grant;
    rx_valid_n = '0;
    req_done_n = '0;
    rx_data_n = rx_data;
    n_ss_n = n_ss;
    spi_start = 1'b0;
    spi_tx_data = '0;
    tx_pop = '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_n = NUM_REQ'(1) << win;
          own_n = win;
          ptr_n = win;
          cnt_n = (win_len == '0) ?
            LEN_W'(1) : win_len;
          n_ss_n = 1'b0;
          tmr_n = '0;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (tmr == TW'(SETUP_CYC - 1)) begin
          tmr_n = '0;
          state_n = XFER;
        end else begin
          tmr_n = tmr + TW'(1);
        end
      end
      XFER: begin
        if (bus.spi_ready) begin
          spi_start = 1'b1;
          spi_tx_data =
            bus.tx_data[int'(own)*8 +: 8];
          tx_pop = own_oh;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (bus.spi_done) begin
          rx_data_n = bus.spi_rx_data;
          rx_valid_n = own_oh;
          cnt_n = cnt - LEN_W'(1);
          tmr_n = '0;
          state_n = (cnt <= LEN_W'(1)) ?
            HOLD : XFER;
        end
      end
      HOLD: begin
        if (tmr == TW'(HOLD_CYC - 1)) begin
          n_ss_n = 1'b1;
          grant_n = '0;
          req_done_n = own_oh;
          tmr_n = '0;
          state_n = GAP;
        end else begin
          tmr_n = tmr + TW'(1);
        end
      end
      GAP: begin
        if (tmr == TW'(GAP_CYC - 1)) begin
          tmr_n = '0;
          state_n = IDLE;
        end else begin
          tmr_n = tmr + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= IW'(NUM_REQ - 1);
      own <= '0;
      cnt <= '0;
      tmr <= '0;
      grant <= '0;
      rx_valid <= '0;
      req_done <= '0;
      rx_data <= '0;
      n_ss <= 1'b1;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      own <= own_n;
      cnt <= cnt_n;
      tmr <= tmr_n;
      grant <= grant_n;
      rx_valid <= rx_valid_n;
      req_done <= req_done_n;
      rx_data <= rx_data_n;
      n_ss <= n_ss_n;
    end
  end

  assign bus.grant = grant;
  assign bus.tx_pop = tx_pop;
  assign bus.rx_data = rx_data;
  assign bus.rx_valid = rx_valid;
  assign bus.req_done = req_done;
  assign bus.busy = (state != IDLE);
  assign bus.spi_start = spi_start;
  assign bus.spi_tx_data = spi_tx_data;
  assign bus.n_SS = n_ss;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Scoreboard bench for spi_master_arbiter: burst-order model,
// requester and SPI slave models, decoupled output monitor.
module tb_spi_master_arbiter;
  localparam int NR = 2;
  localparam int LW = 4;
  localparam int SETUP = 2;
  localparam int HOLD = 2;
  localparam int GAP = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_master_arbiter_if #(.NUM_REQ(NR), .LEN_W(LW)) bus();

  spi_master_arbiter #(
    .NUM_REQ(NR), .LEN_W(LW), .SETUP_CYC(SETUP),
    .HOLD_CYC(HOLD), .GAP_CYC(GAP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int exp_grant[$];
  int exp_len[$];
  int exp_done[$];
  int exp_tx[$];
  int exp_rx[$];
  int dir_len[$];
  int dir_tx[$];
  int dir_rx[$];
  int txq[NR][$];
  int lenq[NR][$];
  int total[NR] = '{default: 0};
  int done_cnt[NR] = '{default: 0};

  int mptr = NR - 1;
  bit stall = 1'b0;
  bit rand_ready = 1'b0;
  int dly = 0;
  int spur_cnt = 0;
  int n_start = 0;

  int cur_owner = 0;
  int cur_len = 0;
  int nbytes = 0;
  int grant_cyc = 0;
  int last_done = 0;
  int hi_run = 0;
  bit first_start = 1'b0;
  bit rdy_low = 1'b0;
  logic [NR-1:0] prev_grant = '0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic miss(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got an output with nothing expected (cycle %0d)",
             nm, cyc);
  endtask

  // requesters: byte/length queues, level request
  initial begin
    logic [NR-1:0] tp, rd;
    bus.req_valid = '0;
    bus.req_len = '0;
    bus.tx_data = '0;
    bus.spi_ready = 1'b1;
    forever begin
      @(negedge clk);
      tp = bus.tx_pop;
      rd = bus.req_done;
      @(posedge clk);
      #2;
      for (int i = 0; i < NR; i++) begin
        if (tp[i] && txq[i].size() > 0)
          void'(txq[i].pop_front());
        if (rd[i]) begin
          done_cnt[i]++;
          if (lenq[i].size() > 0)
            void'(lenq[i].pop_front());
        end
        bus.req_valid[i] = done_cnt[i] < total[i];
        bus.tx_data[i*8 +: 8] =
          txq[i].size() > 0 ? 8'(txq[i][0]) : 8'h00;
        bus.req_len[i*LW +: LW] =
          lenq[i].size() > 0 ? LW'(lenq[i][0]) : '0;
      end
      bus.spi_ready = !stall &&
        (!rand_ready || $urandom_range(0, 3) != 0);
    end
  end

  // SPI slave: answers each start with one done
  initial begin
    int pend;
    int b;
    int spur_seen;
    bit st;
    bit rs;
    pend = 0;
    spur_seen = 0;
    bus.spi_done = 1'b0;
    bus.spi_rx_data = '0;
    forever begin
      @(negedge clk);
      st = bus.spi_start;
      rs = reset;
      @(posedge clk);
      #1;
      bus.spi_done = 1'b0;
      if (rs)
        pend = 0;
      else if (st)
        pend = dly > 0 ? dly : int'($urandom_range(1, 3));
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          b = dir_rx.size() > 0 ? dir_rx.pop_front() :
              int'($urandom_range(0, 255));
          bus.spi_done = 1'b1;
          bus.spi_rx_data = 8'(b);
          exp_rx.push_back(cur_owner * 256 + b);
        end
      end else if (spur_cnt != spur_seen) begin
        spur_seen = spur_cnt;
        bus.spi_done = 1'b1;
        bus.spi_rx_data = 8'hEE;
      end
    end
  end

  // monitor: pops expectations whenever the DUT produces output
  always @(negedge clk) begin
    int e;
    cyc++;
    if (reset) begin
      prev_grant = '0;
      hi_run = bus.n_SS ? hi_run + 1 : 0;
    end else begin
      chk("grant_onehot", int'($onehot0(bus.grant)), 1);
      chk("nss_vs_grant", int'(bus.n_SS),
          int'(bus.grant == '0));
      if (bus.grant != '0)
        chk("busy_in_burst", int'(bus.busy), 1);
      if (bus.grant != '0 && prev_grant == '0) begin
        chk("gap_nss_high", int'(hi_run >= GAP + 1), 1);
        if (exp_grant.size() == 0) begin
          miss("grant");
        end else begin
          cur_owner = exp_grant.pop_front();
          cur_len = exp_len.pop_front();
          chk("grant", int'(bus.grant), 1 << cur_owner);
        end
        nbytes = 0;
        grant_cyc = cyc;
        first_start = 1'b1;
        rdy_low = 1'b0;
      end
      if (!bus.spi_ready)
        rdy_low = 1'b1;
      if (bus.spi_start) begin
        n_start++;
        nbytes++;
        chk("start_with_ready", int'(bus.spi_ready), 1);
        if (exp_tx.size() == 0) begin
          miss("spi_start");
        end else begin
          e = exp_tx.pop_front();
          chk("spi_tx_data", int'(bus.spi_tx_data), e & 255);
          chk("tx_pop", int'(bus.tx_pop), 1 << (e >> 8));
        end
        if (first_start && !rdy_low)
          chk("setup_delay", cyc - grant_cyc, SETUP);
        first_start = 1'b0;
      end else begin
        chk("pop_without_start", int'(bus.tx_pop), 0);
      end
      if (bus.spi_done)
        last_done = cyc;
      if (bus.rx_valid != '0) begin
        if (exp_rx.size() == 0) begin
          miss("rx_valid");
        end else begin
          e = exp_rx.pop_front();
          chk("rx_valid", int'(bus.rx_valid), 1 << (e >> 8));
          chk("rx_data", int'(bus.rx_data), e & 255);
        end
      end
      if (bus.req_done != '0) begin
        if (exp_done.size() == 0) begin
          miss("req_done");
        end else begin
          e = exp_done.pop_front();
          chk("req_done", int'(bus.req_done), 1 << e);
          chk("burst_bytes", nbytes, cur_len);
          chk("hold_delay", cyc - last_done, HOLD + 1);
        end
      end
      hi_run = bus.n_SS ? hi_run + 1 : 0;
      prev_grant = bus.grant;
    end
  end

  // reference: all listed requests rise together while idle;
  // each burst goes to the next pending requester after the last owner
  task automatic plan(input int c0, input int c1,
                      input int maxlen);
    int c[NR];
    int idx, len, eff, b;
    c[0] = c0;
    c[1] = c1;
    while (c[0] + c[1] > 0) begin
      idx = mptr;
      do idx = (idx + 1) % NR; while (c[idx] == 0);
      mptr = idx;
      c[idx]--;
      len = dir_len.size() > 0 ? dir_len.pop_front() :
            int'($urandom_range(0, maxlen));
      eff = len == 0 ? 1 : len;
      lenq[idx].push_back(len);
      exp_grant.push_back(idx);
      exp_len.push_back(eff);
      exp_done.push_back(idx);
      for (int k = 0; k < eff; k++) begin
        b = dir_tx.size() > 0 ? dir_tx.pop_front() :
            int'($urandom_range(0, 255));
        txq[idx].push_back(b);
        exp_tx.push_back(idx * 256 + b);
      end
    end
    @(posedge clk);
    #1;
    total[0] = done_cnt[0] + c0;
    total[1] = done_cnt[1] + c1;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_done.size() > 0 || bus.busy) && n < 3000);
    chk({nm, "_completes"}, int'(n < 3000), 1);
  endtask

  task automatic wait_grant(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.grant == '0 && n < 50);
    chk({nm, "_granted"}, int'(bus.grant != '0), 1);
  endtask

  initial begin
    int c0, c1, base, n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", int'(bus.grant), 0);
    chk("rst_nss", int'(bus.n_SS), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_rx_data", int'(bus.rx_data), 0);
    chk("rst_rx_valid", int'(bus.rx_valid), 0);
    chk("rst_req_done", int'(bus.req_done), 0);
    chk("rst_tx_pop", int'(bus.tx_pop), 0);
    chk("rst_spi_start", int'(bus.spi_start), 0);
    chk("rst_spi_tx", int'(bus.spi_tx_data), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    dir_len = '{1, 1, 1, 1};
    plan(2, 2, 0);
    wait_idle("alternate");

    dir_len = '{2};
    dir_tx = '{8'hA5, 8'h3C};
    dir_rx = '{8'h11, 8'h22};
    plan(1, 0, 0);
    wait_idle("single");

    dir_len = '{0};
    plan(0, 1, 0);
    wait_idle("len_zero");

    dir_len = '{1};
    plan(1, 0, 0);
    wait_grant("stall");
    @(posedge clk);
    #1 stall = 1'b1;
    repeat (11) begin
      @(negedge clk);
      chk("stall_start", int'(bus.spi_start), 0);
      chk("stall_pop", int'(bus.tx_pop), 0);
      chk("stall_nss", int'(bus.n_SS), 0);
    end
    @(posedge clk);
    #1 stall = 1'b0;
    @(negedge clk);
    chk("start_on_ready", int'(bus.spi_start), 1);
    wait_idle("stall");

    dir_len = '{3};
    plan(0, 1, 0);
    wait_grant("spurious");
    spur_cnt++;
    repeat (4) @(posedge clk);
    #1 total[1] = done_cnt[1];
    wait_idle("drop_mid_burst");

    dir_len = '{15};
    plan(1, 0, 0);
    wait_idle("max_len");

    rand_ready = 1'b1;
    for (int r = 0; r < 25; r++) begin
      c0 = int'($urandom_range(0, 3));
      c1 = int'($urandom_range(0, 3));
      if (c0 + c1 == 0) c0 = 1;
      plan(c0, c1, 15);
      wait_idle("random");
    end
    rand_ready = 1'b0;

    dly = 5;
    dir_len = '{3};
    base = n_start;
    plan(1, 0, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n_start < base + 2 && n < 100);
    chk("second_byte_started", int'(n_start >= base + 2), 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_nss", int'(bus.n_SS), 1);
    chk("abort_grant", int'(bus.grant), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_req_done", int'(bus.req_done), 0);
    exp_grant.delete();
    exp_len.delete();
    exp_done.delete();
    exp_tx.delete();
    exp_rx.delete();
    for (int i = 0; i < NR; i++) begin
      txq[i].delete();
      lenq[i].delete();
      total[i] = done_cnt[i];
    end
    mptr = NR - 1;
    dly = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    plan(1, 1, 4);
    wait_idle("after_reset");

    repeat (4) @(negedge clk);
    chk("leftover_expectations",
        exp_tx.size() + exp_rx.size() +
        exp_grant.size() + exp_done.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
